// File: rtl/ase_pcie_ss_pkg.sv
// Shared types for the AFU->host TX arbiter and its round-robin picker.
// Width defaults mirror the OFS PCIe SS configuration (512-bit data, 10-bit tuser_vendor).
package ase_pcie_ss_pkg;

   localparam int unsigned PCIE_TDATA_WIDTH        = 512;
   localparam int unsigned PCIE_TUSER_VENDOR_WIDTH = 10;
   localparam int unsigned MAX_SRC                 = 8;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } t_tx_arb_state;

   // Widest source index any arbiter/picker in this slice may need.
   typedef logic [$clog2(MAX_SRC)-1:0] t_src_idx;

   function automatic int unsigned src_idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ase_pcie_ss_rr_picker.sv
// Combinational rotate-priority picker: first asserted request at or above i_ptr (mod N) wins.
// Shared by the TX arbiter and the RX-side demux scheduler.
module ase_pcie_ss_rr_picker
   import ase_pcie_ss_pkg::*;
#(
   parameter int unsigned N  = 4,
   parameter int unsigned IW = src_idx_width(N)
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic [N-1:0]  o_gnt,
   output logic [IW-1:0] o_idx
);

   logic        w_found;
   int unsigned w_j;

   always_comb begin
      o_gnt   = '0;
      o_idx   = '0;
      w_found = 1'b0;
      w_j     = 0;
      for (int unsigned k = 0; k < N; k++) begin
         w_j = (32'(i_ptr) + k) % N;
         if (!w_found && i_req[IW'(w_j)]) begin
            w_found           = 1'b1;
            o_gnt[IW'(w_j)]   = 1'b1;
            o_idx             = IW'(w_j);
         end
      end
   end

endmodule

// File: rtl/ase_pcie_ss_tx_arbiter.sv
// Packet-atomic round-robin merge of NUM_SRC AXI-S TLP streams with a registered output stage.
// Optional: define ASE_PCIE_SS_TX_ARB_SRC0_PRIORITY_EN to let source 0 win every IDLE arbitration.
module ase_pcie_ss_tx_arbiter
   import ase_pcie_ss_pkg::*;
#(
   parameter int unsigned NUM_SRC     = 4,
   parameter int unsigned TDATA_WIDTH = PCIE_TDATA_WIDTH,
   parameter int unsigned TUSER_WIDTH = PCIE_TUSER_VENDOR_WIDTH,
   parameter int unsigned CNT_WIDTH   = 16
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic [NUM_SRC-1:0]                     in_tvalid,
   output logic [NUM_SRC-1:0]                     in_tready,
   input  logic [NUM_SRC-1:0]                     in_tlast,
   input  logic [NUM_SRC-1:0][TDATA_WIDTH-1:0]    in_tdata,
   input  logic [NUM_SRC-1:0][TDATA_WIDTH/8-1:0]  in_tkeep,
   input  logic [NUM_SRC-1:0][TUSER_WIDTH-1:0]    in_tuser,
   output logic                                   out_tvalid,
   output logic                                   out_tlast,
   output logic [TDATA_WIDTH-1:0]                 out_tdata,
   output logic [TDATA_WIDTH/8-1:0]               out_tkeep,
   output logic [TUSER_WIDTH-1:0]                 out_tuser,
   input  logic                                   out_tready,
   output logic [$clog2(NUM_SRC)-1:0]             grant_id,
   output logic                                   busy,
   output logic [NUM_SRC-1:0][CNT_WIDTH-1:0]      pkt_count
);

   localparam int unsigned IW = src_idx_width(NUM_SRC);
   localparam int unsigned KW = TDATA_WIDTH / 8;

   t_tx_arb_state                      r_state, w_state_nxt;
   logic [IW-1:0]                      r_rr_ptr, r_grant;
   logic                               r_out_tvalid, r_out_tlast;
   logic [TDATA_WIDTH-1:0]             r_out_tdata;
   logic [KW-1:0]                      r_out_tkeep;
   logic [TUSER_WIDTH-1:0]             r_out_tuser;
   logic [NUM_SRC-1:0][CNT_WIDTH-1:0]  r_pkt_count;

   logic [NUM_SRC-1:0]                 w_pick_gnt, w_idle_gnt, w_sel_oh;
   logic [IW-1:0]                      w_pick_idx, w_idle_idx, w_sel;
   logic                               w_out_ready, w_accept, w_accept_last;

   ase_pcie_ss_rr_picker #(
      .N  (NUM_SRC),
      .IW (IW)
   ) u_picker (
      .i_req (in_tvalid),
      .i_ptr (r_rr_ptr),
      .o_gnt (w_pick_gnt),
      .o_idx (w_pick_idx)
   );

`ifdef ASE_PCIE_SS_TX_ARB_SRC0_PRIORITY_EN
   // Source 0 bypasses the rotation; the others still rotate via r_rr_ptr.
   assign w_idle_gnt = in_tvalid[0] ? {{(NUM_SRC-1){1'b0}}, 1'b1} : w_pick_gnt;
   assign w_idle_idx = in_tvalid[0] ? '0 : w_pick_idx;
`else
   assign w_idle_gnt = w_pick_gnt;
   assign w_idle_idx = w_pick_idx;
`endif

   always_comb begin
      w_out_ready = !r_out_tvalid || out_tready;
      w_sel_oh    = '0;
      w_sel       = r_grant;
      if (r_state == IDLE) begin
         w_sel_oh = w_idle_gnt;
         w_sel    = w_idle_idx;
      end else begin
         w_sel_oh[r_grant] = 1'b1;
      end
      in_tready     = (rst_n && w_out_ready) ? w_sel_oh : '0;
      w_accept      = |(in_tready & in_tvalid);
      w_accept_last = w_accept && in_tlast[w_sel];
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_accept && !w_accept_last) w_state_nxt = LOCKED;
         LOCKED:  if (w_accept_last)              w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rr_ptr     <= '0;
         r_grant      <= '0;
         r_out_tvalid <= 1'b0;
         r_out_tlast  <= 1'b0;
         r_out_tdata  <= '0;
         r_out_tkeep  <= '0;
         r_out_tuser  <= '0;
         r_pkt_count  <= '0;
      end else begin
         if (w_out_ready) begin
            r_out_tvalid <= w_accept;
            if (w_accept) begin
               r_out_tlast <= in_tlast[w_sel];
               r_out_tdata <= in_tdata[w_sel];
               r_out_tkeep <= in_tkeep[w_sel];
               r_out_tuser <= in_tuser[w_sel];
            end
         end
         if (r_state == IDLE && w_accept && !w_accept_last)
            r_grant <= w_sel;
         if (w_accept_last) begin
            r_rr_ptr            <= (w_sel == IW'(NUM_SRC - 1)) ? '0 : w_sel + IW'(1);
            r_pkt_count[w_sel]  <= r_pkt_count[w_sel] + CNT_WIDTH'(1);
         end
      end
   end

   assign out_tvalid = r_out_tvalid;
   assign out_tlast  = r_out_tlast;
   assign out_tdata  = r_out_tdata;
   assign out_tkeep  = r_out_tkeep;
   assign out_tuser  = r_out_tuser;
   assign grant_id   = r_grant;
   assign busy       = (r_state == LOCKED);
   assign pkt_count  = r_pkt_count;

endmodule

// File: doc/ase_pcie_ss_tx_arbiter.md
# ase_pcie_ss_tx_arbiter

Packet-atomic arbiter that merges NUM_SRC AFU-side AXI-S PCIe SS TLP streams onto the single AFU→host TX stream consumed by the PCIe SS emulator. Multi-beat TLPs are never interleaved. Selection is round-robin across sources. A registered output stage isolates the downstream tready path. The block sits between the AFU-side request/completion generators and the emulator's TX sink.

## Interface
Parameters:
- NUM_SRC, 4: number of input streams, 2..8.
- TDATA_WIDTH, ofs_pcie_ss_cfg_pkg::TDATA_WIDTH: data width in bits.
- TUSER_WIDTH, ofs_pcie_ss_cfg_pkg::TUSER_VENDOR_WIDTH: tuser_vendor width.
- CNT_WIDTH, 16: width of each per-source packet counter.

Ports:
- clk  in  1  block clock. Single clock domain.
- rst_n  in  1  reset, synchronous, active-low.
- in_tvalid  in  [NUM_SRC]  per-source beat valid.
- in_tready  out  [NUM_SRC]  per-source beat accept.
- in_tlast  in  [NUM_SRC]  last beat of TLP.
- in_tdata  in  [NUM_SRC][TDATA_WIDTH]  beat data.
- in_tkeep  in  [NUM_SRC][TDATA_WIDTH/8]  byte enables.
- in_tuser  in  [NUM_SRC][TUSER_WIDTH]  tuser_vendor.
- out_tvalid / out_tlast / out_tdata / out_tkeep / out_tuser  out  1/1/TDATA/TKEEP/TUSER  merged stream toward the emulator.
- out_tready  in  1  downstream accept.
- grant_id  out  $clog2(NUM_SRC)  source currently locked. Meaningful only while busy.
- busy  out  1  a packet is in progress.
- pkt_count  out  [NUM_SRC][CNT_WIDTH]  completed packets forwarded per source.

## Operation
- Two-state FSM.
  - IDLE: arbitrate among asserted in_tvalid.
    - Search starts at rr_ptr and proceeds upward modulo NUM_SRC. The first valid source wins.
    - The winner's first beat is accepted in the same cycle if the output register can load.
    - The FSM moves to LOCKED, or stays IDLE if that beat carried tlast.
  - LOCKED: only the granted source may transfer. All other in_tready are 0. Return to IDLE when a beat with tlast is accepted.
- Output register load condition: out_ready_int = !out_tvalid || out_tready.
- in_tready[i] = out_ready_int && (selected source == i). Valid in IDLE for the arbitration winner and in LOCKED for the granted source.
- On acceptance of a tlast beat from source g:
  - rr_ptr ← (g+1) mod NUM_SRC.
  - pkt_count[g] increments and wraps modulo 2^CNT_WIDTH.
- Single-beat TLPs (tlast on first beat) complete in IDLE with no LOCKED cycle.
- in_tvalid must not drop mid-packet. The arbiter does not detect this; gaps simply stall LOCKED.

## Timing
- Reset (rst_n=0 at a clk edge): state=IDLE, rr_ptr=0, out_tvalid=0, out_tlast=0, out_tdata/tkeep/tuser=0, busy=0, grant_id=0, pkt_count=0, all in_tready=0.
- While rst_n=0, in_tready=0. A reset mid-packet discards the partial packet and the output register contents, with no flush.
- Latency: a beat accepted at edge N appears on out_* after edge N, i.e. 1 cycle.
- Throughput: 1 beat/cycle within a packet and for back-to-back single-beat TLPs. Arbitration after a multi-beat tlast happens in IDLE on the next cycle, with zero bubble if a request is pending.
- Output holds stable while out_tvalid && !out_tready (AXI-S rule).
- busy=1 exactly while state=LOCKED. grant_id updates at the edge entering LOCKED.
- Simultaneous requests from all sources after reset: grant order is 0,1,2,3,0…

## Configuration
- ASE_PCIE_SS_TX_ARB_SRC0_PRIORITY_EN
  - Defined: in IDLE, source 0 wins whenever in_tvalid[0]=1, regardless of rr_ptr. Other sources remain round-robin among themselves. Used to let MMIO read completions bypass DMA request traffic.
  - Undefined: pure round-robin as above.
  - In both cases packets remain atomic. Priority never preempts a LOCKED packet.

## Structure
- Shared package ase_pcie_ss_pkg holds the state enum t_tx_arb_state (IDLE, LOCKED) and the source-index typedef helper.
- One sub-module, ase_pcie_ss_rr_picker: combinational rotate-priority picker.
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant and encoded index.
  - Also reusable for the RX-side demux scheduler.

## Test plan
- Single source: src 2 sends a 3-beat TLP with out_tready=1 → out beats 1 cycle delayed, identical data, busy=1 for 2 cycles, pkt_count[2]=1, rr_ptr=3.
- All 4 sources hold 2-beat TLPs continuously → output order 0,1,2,3,0, no interleaving, each packet contiguous.
- Backpressure: out_tready=0 for 5 cycles mid-packet → out_* stable, in_tready=0, no beat lost or duplicated after release.
- Src-0 priority with macro defined: rr_ptr=2, srcs 0 and 2 valid → src 0 granted. Without the macro → src 2 granted.
- Reset mid-packet: rst_n=0 on beat 2 of 4 → next cycle out_tvalid=0, pkt_count=0, state=IDLE. A new packet from src 1 then forwards normally.
- Counter wrap with CNT_WIDTH=4: 17 single-beat TLPs from src 0 → pkt_count[0]=1.
